// File: rtl/my2_fsm_control.sv
// my2_fsm_control: divides by repeated subtraction on an external datapath (in: start, operands, x, result; out: s, we, a, b, busy, done, err, quotient, remainder)
module my2_fsm_control #(
  parameter logic [31:0] MAX_ITER = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        x,
  input  logic [31:0] result,
  output logic        s,
  output logic        we,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  typedef enum logic [2:0] {IDLE, LOAD, SUB, DONE, ERR} state_t;
  state_t state, state_n;
  logic s_n, we_n, busy_n, done_n, err_n, bad_req;
  logic [31:0] a_n, b_n, q_n, r_n;
  assign bad_req = (divisor == '0) | divisor[31] | dividend[31];
  always_comb begin
    state_n = state;
    s_n = s;
    we_n = 1'b0;
    a_n = a;
    b_n = b;
    busy_n = busy;
    done_n = 1'b0;
    err_n = 1'b0;
    q_n = quotient;
    r_n = remainder;
    case (state)
      IDLE: if (start) begin
        if (bad_req) state_n = ERR;
        else begin
          a_n = dividend;
          b_n = ~divisor + 32'd1;
          q_n = '0;
          s_n = 1'b0;
          we_n = 1'b1;
          busy_n = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        s_n = 1'b1;
        state_n = SUB;
      end
      SUB: if (!x) begin
        if (quotient == MAX_ITER) state_n = ERR;
        else begin
          q_n = quotient + 32'd1;
          s_n = 1'b1;
          we_n = 1'b1;
        end
      end else begin
        r_n = result;
        state_n = DONE;
      end
      DONE: begin
        done_n = 1'b1;
        busy_n = 1'b0;
        state_n = IDLE;
      end
      ERR: begin
        err_n = 1'b1;
        busy_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      s <= 1'b0;
      we <= 1'b0;
      a <= '0;
      b <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      quotient <= '0;
      remainder <= '0;
    end else begin
      state <= state_n;
      s <= s_n;
      we <= we_n;
      a <= a_n;
      b <= b_n;
      busy <= busy_n;
      done <= done_n;
      err <= err_n;
      quotient <= q_n;
      remainder <= r_n;
    end
  end
endmodule

// File: tb/tb_my2_fsm_control.sv
// tb_my2_fsm_control: directed checks of the divider controller against a behavioural datapath
module tb_my2_fsm_control;
  logic CLK = 1'b0, RST_N = 1'b0, start = 1'b0, start16 = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic x, s, we, busy, done, err;
  logic [31:0] result, a, b, quotient, remainder;
  logic x16, s16, we16, busy16, done16, err16;
  logic [31:0] result16, a16, b16, quotient16, remainder16;
  logic [31:0] temp = '0, temp16 = '0, sum, sum16;
  int total = 0, bad = 0;
  int done_at, err_at, we_cnt, last_we;

  always #5 CLK = ~CLK;

  assign sum = temp + b;
  assign x = sum[31];
  assign result = temp;
  always @(negedge CLK) if (we) temp <= s ? sum : a;

  assign sum16 = temp16 + b16;
  assign x16 = sum16[31];
  assign result16 = temp16;
  always @(negedge CLK) if (we16) temp16 <= s16 ? sum16 : a16;

  my2_fsm_control dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .dividend(dividend), .divisor(divisor),
    .x(x), .result(result), .s(s), .we(we), .a(a), .b(b), .busy(busy), .done(done),
    .err(err), .quotient(quotient), .remainder(remainder)
  );

  my2_fsm_control #(.MAX_ITER(32'd16)) dut16 (
    .CLK(CLK), .RST_N(RST_N), .start(start16), .dividend(dividend), .divisor(divisor),
    .x(x16), .result(result16), .s(s16), .we(we16), .a(a16), .b(b16), .busy(busy16),
    .done(done16), .err(err16), .quotient(quotient16), .remainder(remainder16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input logic [31:0] dvd, input logic [31:0] dvs, input bit poke, input int bound);
    dividend = dvd;
    divisor = dvs;
    start = 1'b1;
    tick();
    start = 1'b0;
    we_cnt = int'(we);
    done_at = 0;
    err_at = 0;
    for (int n = 1; n <= bound; n++) begin
      if (poke && n == 5) begin
        start = 1'b1;
        dividend = 32'd50;
        divisor = 32'd5;
      end
      if (poke && n == 6) start = 1'b0;
      tick();
      we_cnt += int'(we);
      if (done) done_at = n;
      if (err) err_at = n;
      if (done || err) begin
        chk("busy_low_at_end", {31'd0, busy}, 32'd0);
        break;
      end
    end
    tick();
    chk("pulse_one_cycle", {30'd0, done, err}, 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_s", {31'd0, s}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_a", a, 32'd0);
    chk("rst_b", b, 32'd0);
    chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    #11;
    RST_N = 1'b1;
    tick();
    chk("idle_after_rst", {29'd0, busy, done, err}, 32'd0);

    run(32'd100, 32'd7, 1'b0, 40);
    chk("t1_done_at", done_at, 32'd17);
    chk("t1_we_cycles", we_cnt, 32'd15);
    chk("t1_quotient", quotient, 32'd14);
    chk("t1_remainder", remainder, 32'd2);
    chk("t1_a", a, 32'd100);
    chk("t1_b", b, 32'hFFFF_FFF9);

    run(32'd5, 32'd9, 1'b0, 40);
    chk("t2_done_at", done_at, 32'd3);
    chk("t2_we_cycles", we_cnt, 32'd1);
    chk("t2_quotient", quotient, 32'd0);
    chk("t2_remainder", remainder, 32'd5);

    run(32'd42, 32'd42, 1'b0, 40);
    chk("t3a_quotient", quotient, 32'd1);
    chk("t3a_remainder", remainder, 32'd0);
    chk("t3a_done_at", done_at, 32'd4);
    run(32'h7FFF_FFFF, 32'h4000_0000, 1'b0, 40);
    chk("t3b_quotient", quotient, 32'd1);
    chk("t3b_remainder", remainder, 32'h3FFF_FFFF);

    run(32'd10, 32'd0, 1'b0, 10);
    chk("t4a_err_at", err_at, 32'd1);
    chk("t4a_no_done", done_at, 32'd0);
    chk("t4a_no_we", we_cnt, 32'd0);
    chk("t4a_quotient_kept", quotient, 32'd1);
    chk("t4a_remainder_kept", remainder, 32'h3FFF_FFFF);
    run(32'h8000_0000, 32'd3, 1'b0, 10);
    chk("t4b_err_at", err_at, 32'd1);
    chk("t4b_no_we", we_cnt, 32'd0);
    chk("t4b_quotient_kept", quotient, 32'd1);
    chk("t4b_remainder_kept", remainder, 32'h3FFF_FFFF);
    chk("t4b_a_kept", a, 32'h7FFF_FFFF);

    dividend = 32'd1000;
    divisor = 32'd1;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    err_at = 0;
    done_at = 0;
    last_we = 1;
    for (int n = 1; n <= 40; n++) begin
      last_we = int'(we16);
      tick();
      if (done16) done_at = n;
      if (err16) begin
        err_at = n;
        break;
      end
    end
    chk("t5_err_at", err_at, 32'd19);
    chk("t5_no_done", done_at, 32'd0);
    chk("t5_we_low_in_err", last_we, 32'd0);
    chk("t5_quotient", quotient16, 32'd16);
    tick();
    chk("t5_err_one_cycle", {31'd0, err16}, 32'd0);

    dividend = 32'd1000;
    divisor = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("t6_busy_mid_sub", {31'd0, busy}, 32'd1);
    chk("t6_we_mid_sub", {31'd0, we}, 32'd1);
    RST_N = 1'b0;
    #1;
    chk("t6_async_we", {31'd0, we}, 32'd0);
    chk("t6_async_busy", {31'd0, busy}, 32'd0);
    chk("t6_async_quotient", quotient, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    chk("t6_idle_after_rst", {28'd0, busy, done, err, we}, 32'd0);
    run(32'd1000, 32'd3, 1'b1, 400);
    chk("t6_done_at", done_at, 32'd336);
    chk("t6_quotient", quotient, 32'd333);
    chk("t6_remainder", remainder, 32'd1);
    chk("t6_a_latched", a, 32'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
